// File: rtl/wb_arbiter.sv
// Writeback arbiter for the register-file write port.
// ALU results have priority. Load responses are extended at push time
// and buffered in a small FIFO. A starvation counter forces a FIFO pop
// after MAX_STARVE consecutive ALU wins while loads are waiting.
module wb_arbiter #(
  parameter int FIFO_DEPTH = 2,
  parameter int MAX_STARVE = 4
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_alu_valid,
  input  logic [4:0]  i_alu_rd_addr,
  input  logic [31:0] i_alu_rd_data,
  output logic        o_alu_stall,
  input  logic        i_mem_valid,
  output logic        o_mem_ready,
  input  logic [4:0]  i_mem_rd_addr,
  input  logic [31:0] i_mem_data,
  input  logic [2:0]  i_mem_funct3,
  input  logic [1:0]  i_mem_addr_lo,
  output logic [4:0]  o_rd_addr,
  output logic [31:0] o_rd_data,
  output logic        o_rd_wren
);

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
  localparam int STV_W = (MAX_STARVE > 0) ? $clog2(MAX_STARVE + 1) : 1;

  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(FIFO_DEPTH - 1);
  localparam logic [CNT_W-1:0] DEPTH_C  = CNT_W'(FIFO_DEPTH);
  localparam logic [STV_W-1:0] STARVE_C = STV_W'(MAX_STARVE);

  typedef struct packed {
    logic [4:0]  addr;
    logic [31:0] data;
  } entry_t;

  entry_t            mem_q [FIFO_DEPTH];
  entry_t            mem_d [FIFO_DEPTH];
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic [STV_W-1:0]  starve_q, starve_d;
  logic [4:0]        rd_addr_q, rd_addr_d;
  logic [31:0]       rd_data_q, rd_data_d;
  logic              rd_wren_q, rd_wren_d;

  logic              fifo_empty;
  logic              force_pop;
  logic              pop;
  logic              push;
  logic              mem_ready;
  entry_t            push_entry;

  // Byte/half selection with sign or zero extension; LW and unknown codes pass the word.
  function automatic logic [31:0] load_extend(input logic [31:0] word,
                                              input logic [2:0]  funct3,
                                              input logic [1:0]  off);
    logic signed [7:0]  byte_s;
    logic signed [15:0] half_s;
    logic [31:0]        res;
    case (off)
      2'd0:    byte_s = word[7:0];
      2'd1:    byte_s = word[15:8];
      2'd2:    byte_s = word[23:16];
      default: byte_s = word[31:24];
    endcase
    half_s = off[1] ? word[31:16] : word[15:0];
    case (funct3)
      3'b000:  res = 32'(byte_s);
      3'b100:  res = {24'b0, byte_s};
      3'b001:  res = 32'(half_s);
      3'b101:  res = {16'b0, half_s};
      default: res = word;
    endcase
    return res;
  endfunction

  // Circular pointer advance that also works for non power-of-two depths.
  function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] ptr);
    return (ptr == PTR_LAST) ? '0 : ptr + PTR_W'(1);
  endfunction

  // Arbitration, FIFO bookkeeping and next output-register values.
  always_comb begin
    fifo_empty = (count_q == '0);
    force_pop  = !fifo_empty && (starve_q == STARVE_C);
    mem_ready  = (count_q < DEPTH_C);
    push       = i_mem_valid && mem_ready;
    pop        = force_pop || (!i_alu_valid && !fifo_empty);

    push_entry.addr = i_mem_rd_addr;
    push_entry.data = load_extend(i_mem_data, i_mem_funct3, i_mem_addr_lo);

    mem_d     = mem_q;
    rd_ptr_d  = rd_ptr_q;
    wr_ptr_d  = wr_ptr_q;
    count_d   = count_q;
    starve_d  = starve_q;
    rd_addr_d = rd_addr_q;
    rd_data_d = rd_data_q;
    rd_wren_d = 1'b0;

    if (pop) begin
      rd_addr_d = mem_q[rd_ptr_q].addr;
      rd_data_d = mem_q[rd_ptr_q].data;
      rd_wren_d = (mem_q[rd_ptr_q].addr != 5'd0);
      rd_ptr_d  = ptr_next(rd_ptr_q);
      starve_d  = '0;
    end else if (i_alu_valid) begin
      rd_addr_d = i_alu_rd_addr;
      rd_data_d = i_alu_rd_data;
      rd_wren_d = (i_alu_rd_addr != 5'd0);
      if (fifo_empty) begin
        starve_d = '0;
      end else if (starve_q != STARVE_C) begin
        starve_d = starve_q + STV_W'(1);
      end
    end else begin
      starve_d = '0;
    end

    if (push) begin
      mem_d[wr_ptr_q] = push_entry;
      wr_ptr_d        = ptr_next(wr_ptr_q);
    end

    case ({push, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  // Control state and output register; reset discards buffered entries.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      rd_ptr_q  <= '0;
      wr_ptr_q  <= '0;
      count_q   <= '0;
      starve_q  <= '0;
      rd_addr_q <= '0;
      rd_data_q <= '0;
      rd_wren_q <= 1'b0;
    end else begin
      rd_ptr_q  <= rd_ptr_d;
      wr_ptr_q  <= wr_ptr_d;
      count_q   <= count_d;
      starve_q  <= starve_d;
      rd_addr_q <= rd_addr_d;
      rd_data_q <= rd_data_d;
      rd_wren_q <= rd_wren_d;
    end
  end

  // FIFO storage holds data only; validity is tracked by count/pointers.
  always_ff @(posedge i_clk) begin
    mem_q <= mem_d;
  end

  assign o_mem_ready = !i_reset && mem_ready;
  assign o_alu_stall = !i_reset && force_pop;
  assign o_rd_addr   = rd_addr_q;
  assign o_rd_data   = rd_data_q;
  assign o_rd_wren   = rd_wren_q;

endmodule

// File: tb/tb_wb_arbiter.sv
// Bench for wb_arbiter: directed scenarios plus randomized traffic
// checked against a queue-based reference model.
module tb_wb_arbiter;

  localparam int DEPTH      = 2;
  localparam int MAX_STARVE = 4;

  logic        i_clk;
  logic        i_reset;
  logic        i_alu_valid;
  logic [4:0]  i_alu_rd_addr;
  logic [31:0] i_alu_rd_data;
  logic        o_alu_stall;
  logic        i_mem_valid;
  logic        o_mem_ready;
  logic [4:0]  i_mem_rd_addr;
  logic [31:0] i_mem_data;
  logic [2:0]  i_mem_funct3;
  logic [1:0]  i_mem_addr_lo;
  logic [4:0]  o_rd_addr;
  logic [31:0] o_rd_data;
  logic        o_rd_wren;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [4:0]  a;
    logic [31:0] d;
  } ent_t;

  ent_t        mq[$];
  int          mstarve = 0;
  logic [4:0]  m_addr  = '0;
  logic [31:0] m_data  = '0;
  logic        m_wren  = 1'b0;

  wb_arbiter #(.FIFO_DEPTH(DEPTH), .MAX_STARVE(MAX_STARVE)) dut (
    .i_clk         (i_clk),
    .i_reset       (i_reset),
    .i_alu_valid   (i_alu_valid),
    .i_alu_rd_addr (i_alu_rd_addr),
    .i_alu_rd_data (i_alu_rd_data),
    .o_alu_stall   (o_alu_stall),
    .i_mem_valid   (i_mem_valid),
    .o_mem_ready   (o_mem_ready),
    .i_mem_rd_addr (i_mem_rd_addr),
    .i_mem_data    (i_mem_data),
    .i_mem_funct3  (i_mem_funct3),
    .i_mem_addr_lo (i_mem_addr_lo),
    .o_rd_addr     (o_rd_addr),
    .o_rd_data     (o_rd_data),
    .o_rd_wren     (o_rd_wren)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  // Load extension computed arithmetically from the load-type rules.
  function automatic logic [31:0] ref_extend(input logic [31:0] w, input logic [2:0] f3,
                                             input logic [1:0] off);
    longint unsigned uw;
    longint          v;
    uw = w;
    case (f3)
      3'd0: begin v = longint'((uw >> (off * 8)) % 256); if (v >= 128) v -= 256; end
      3'd4: v = longint'((uw >> (off * 8)) % 256);
      3'd1: begin v = longint'((uw >> ((off / 2) * 16)) % 65536); if (v >= 32768) v -= 65536; end
      3'd5: v = longint'((uw >> ((off / 2) * 16)) % 65536);
      default: v = longint'(uw);
    endcase
    return v[31:0];
  endfunction

  // Advance the reference model by one clock edge using the inputs present at that edge.
  task automatic model_edge();
    ent_t e;
    bit   frc;
    bit   rdy;
    if (i_reset) begin
      mq.delete();
      mstarve = 0;
      m_addr  = '0;
      m_data  = '0;
      m_wren  = 1'b0;
      return;
    end
    frc    = (mq.size() > 0) && (mstarve == MAX_STARVE);
    rdy    = (mq.size() < DEPTH);
    m_wren = 1'b0;
    if (frc || (!i_alu_valid && mq.size() > 0)) begin
      e       = mq.pop_front();
      m_addr  = e.a;
      m_data  = e.d;
      m_wren  = (e.a != 0);
      mstarve = 0;
    end else if (i_alu_valid) begin
      m_addr = i_alu_rd_addr;
      m_data = i_alu_rd_data;
      m_wren = (i_alu_rd_addr != 0);
      if (mq.size() > 0) mstarve = (mstarve < MAX_STARVE) ? mstarve + 1 : MAX_STARVE;
      else               mstarve = 0;
    end else begin
      mstarve = 0;
    end
    if (i_mem_valid && rdy) begin
      e.a = i_mem_rd_addr;
      e.d = ref_extend(i_mem_data, i_mem_funct3, i_mem_addr_lo);
      mq.push_back(e);
    end
  endtask

  task automatic tick();
    @(posedge i_clk);
    model_edge();
    #1;
  endtask

  task automatic idle_inputs();
    i_alu_valid   = 1'b0;
    i_alu_rd_addr = '0;
    i_alu_rd_data = '0;
    i_mem_valid   = 1'b0;
    i_mem_rd_addr = '0;
    i_mem_data    = '0;
    i_mem_funct3  = '0;
    i_mem_addr_lo = '0;
  endtask

  task automatic test_reset();
    idle_inputs();
    i_reset     = 1'b1;
    i_mem_valid = 1'b1;
    i_alu_valid = 1'b1;
    #1;
    checks++; if (o_mem_ready !== 1'b0) begin errors++; $display("FAIL reset_ready_during: got %b want 0", o_mem_ready); end
    checks++; if (o_alu_stall !== 1'b0) begin errors++; $display("FAIL reset_stall_during: got %b want 0", o_alu_stall); end
    tick();
    tick();
    idle_inputs();
    i_reset = 1'b0;
    #1;
    checks++; if (o_rd_addr !== 5'd0) begin errors++; $display("FAIL reset_addr: got %0d want 0", o_rd_addr); end
    checks++; if (o_rd_data !== 32'd0) begin errors++; $display("FAIL reset_data: got %h want 0", o_rd_data); end
    checks++; if (o_rd_wren !== 1'b0) begin errors++; $display("FAIL reset_wren: got %b want 0", o_rd_wren); end
    checks++; if (o_mem_ready !== 1'b1) begin errors++; $display("FAIL reset_ready_after: got %b want 1", o_mem_ready); end
    checks++; if (o_alu_stall !== 1'b0) begin errors++; $display("FAIL reset_stall_after: got %b want 0", o_alu_stall); end
  endtask

  task automatic test_alu_only();
    i_alu_valid   = 1'b1;
    i_alu_rd_addr = 5'd5;
    i_alu_rd_data = 32'hDEADBEEF;
    tick();
    idle_inputs();
    checks++; if (o_rd_wren !== 1'b1) begin errors++; $display("FAIL alu_wren: got %b want 1", o_rd_wren); end
    checks++; if (o_rd_addr !== 5'd5) begin errors++; $display("FAIL alu_addr: got %0d want 5", o_rd_addr); end
    checks++; if (o_rd_data !== 32'hDEADBEEF) begin errors++; $display("FAIL alu_data: got %h want deadbeef", o_rd_data); end
    tick();
    checks++; if (o_rd_wren !== 1'b0) begin errors++; $display("FAIL idle_wren: got %b want 0", o_rd_wren); end
    checks++; if (o_rd_addr !== 5'd5 || o_rd_data !== 32'hDEADBEEF) begin
      errors++; $display("FAIL idle_hold: got %0d/%h want 5/deadbeef", o_rd_addr, o_rd_data);
    end
  endtask

  task automatic test_x0();
    i_alu_valid   = 1'b1;
    i_alu_rd_addr = 5'd0;
    i_alu_rd_data = 32'h12345678;
    tick();
    idle_inputs();
    checks++; if (o_rd_wren !== 1'b0) begin errors++; $display("FAIL x0_wren: got %b want 0", o_rd_wren); end
    checks++; if (o_rd_addr !== 5'd0 || o_rd_data !== 32'h12345678) begin
      errors++; $display("FAIL x0_update: got %0d/%h want 0/12345678", o_rd_addr, o_rd_data);
    end
  endtask

  task automatic test_extend();
    logic [2:0]  f3s  [7] = '{3'b000, 3'b100, 3'b001, 3'b101, 3'b010, 3'b011, 3'b000};
    logic [1:0]  offs [7] = '{2'd0, 2'd3, 2'd2, 2'd0, 2'd1, 2'd0, 2'd1};
    logic [31:0] exps [7] = '{32'hFFFFFF81, 32'h00000080, 32'hFFFF80F0, 32'h00007F81,
                              32'h80F07F81, 32'h80F07F81, 32'h0000007F};
    for (int i = 0; i < 7; i++) begin
      i_mem_valid   = 1'b1;
      i_mem_rd_addr = 5'(10 + i);
      i_mem_data    = 32'h80F07F81;
      i_mem_funct3  = f3s[i];
      i_mem_addr_lo = offs[i];
      tick();
      idle_inputs();
      checks++; if (o_rd_wren !== 1'b0) begin errors++; $display("FAIL ext_latency[%0d]: wren %b want 0", i, o_rd_wren); end
      tick();
      checks++; if (o_rd_wren !== 1'b1 || o_rd_addr !== 5'(10 + i) || o_rd_data !== exps[i]) begin
        errors++;
        $display("FAIL ext[%0d]: got wren=%b rd=%0d data=%h want 1/%0d/%h", i, o_rd_wren, o_rd_addr,
                 o_rd_data, 10 + i, exps[i]);
      end
    end
  endtask

  task automatic test_starvation();
    int rd;
    i_alu_valid   = 1'b1;
    i_alu_rd_addr = 5'd1;
    i_alu_rd_data = 32'h101;
    i_mem_valid   = 1'b1;
    i_mem_rd_addr = 5'd20;
    i_mem_data    = 32'h11223344;
    i_mem_funct3  = 3'b010;
    tick();
    i_mem_valid = 1'b0;
    checks++; if (o_rd_addr !== 5'd1 || o_rd_wren !== 1'b1) begin
      errors++; $display("FAIL starve_first: got rd=%0d wren=%b want 1/1", o_rd_addr, o_rd_wren);
    end
    for (rd = 2; rd <= 5; rd++) begin
      i_alu_rd_addr = 5'(rd);
      i_alu_rd_data = 32'(32'h100 + rd);
      #1;
      checks++; if (o_alu_stall !== 1'b0) begin errors++; $display("FAIL starve_early_stall rd%0d: got %b want 0", rd, o_alu_stall); end
      tick();
      checks++; if (o_rd_addr !== 5'(rd) || o_rd_data !== 32'(32'h100 + rd)) begin
        errors++; $display("FAIL starve_alu rd%0d: got %0d/%h", rd, o_rd_addr, o_rd_data);
      end
    end
    i_alu_rd_addr = 5'd6;
    i_alu_rd_data = 32'h106;
    #1;
    checks++; if (o_alu_stall !== 1'b1) begin errors++; $display("FAIL starve_stall: got %b want 1", o_alu_stall); end
    tick();
    checks++; if (o_rd_addr !== 5'd20 || o_rd_data !== 32'h11223344 || o_rd_wren !== 1'b1) begin
      errors++; $display("FAIL starve_retire: got %0d/%h/%b want 20/11223344/1", o_rd_addr, o_rd_data, o_rd_wren);
    end
    #1;
    checks++; if (o_alu_stall !== 1'b0) begin errors++; $display("FAIL starve_release: got %b want 0", o_alu_stall); end
    tick();
    checks++; if (o_rd_addr !== 5'd6 || o_rd_data !== 32'h106) begin
      errors++; $display("FAIL starve_resume: got %0d/%h want 6/106", o_rd_addr, o_rd_data);
    end
    idle_inputs();
  endtask

  task automatic test_full_reset();
    i_alu_valid   = 1'b1;
    i_alu_rd_addr = 5'd3;
    i_alu_rd_data = 32'h33;
    i_mem_valid   = 1'b1;
    i_mem_rd_addr = 5'd21;
    i_mem_data    = 32'hA5A5A5A5;
    i_mem_funct3  = 3'b010;
    tick();
    i_mem_rd_addr = 5'd22;
    #1;
    checks++; if (o_mem_ready !== 1'b1) begin errors++; $display("FAIL full_ready_one: got %b want 1", o_mem_ready); end
    tick();
    #1;
    checks++; if (o_mem_ready !== 1'b0) begin errors++; $display("FAIL full_ready: got %b want 0", o_mem_ready); end
    i_mem_valid = 1'b0;
    i_alu_valid = 1'b0;
    i_reset     = 1'b1;
    tick();
    i_reset = 1'b0;
    checks++; if (o_rd_wren !== 1'b0 || o_rd_addr !== 5'd0 || o_rd_data !== 32'd0) begin
      errors++; $display("FAIL flush_outputs: got %b/%0d/%h want 0/0/0", o_rd_wren, o_rd_addr, o_rd_data);
    end
    for (int i = 0; i < 6; i++) begin
      tick();
      checks++; if (o_rd_wren !== 1'b0) begin
        errors++; $display("FAIL flush_no_write[%0d]: got wren=%b rd=%0d want 0", i, o_rd_wren, o_rd_addr);
      end
    end
    checks++; if (o_mem_ready !== 1'b1) begin errors++; $display("FAIL flush_ready: got %b want 1", o_mem_ready); end
  endtask

  task automatic test_random();
    bit exp_rdy;
    bit exp_stall;
    for (int c = 0; c < 400; c++) begin
      i_reset       = ($urandom_range(0, 79) == 0);
      i_alu_valid   = ($urandom_range(0, 3) != 0);
      i_alu_rd_addr = 5'($urandom_range(0, 31));
      i_alu_rd_data = $urandom();
      i_mem_valid   = ($urandom_range(0, 1) != 0);
      i_mem_rd_addr = 5'($urandom_range(0, 31));
      i_mem_data    = $urandom();
      i_mem_funct3  = 3'($urandom_range(0, 7));
      i_mem_addr_lo = 2'($urandom_range(0, 3));
      #1;
      exp_rdy   = !i_reset && (mq.size() < DEPTH);
      exp_stall = !i_reset && (mq.size() > 0) && (mstarve == MAX_STARVE);
      checks++; if (o_mem_ready !== exp_rdy) begin errors++; $display("FAIL rand_ready c%0d: got %b want %b", c, o_mem_ready, exp_rdy); end
      checks++; if (o_alu_stall !== exp_stall) begin errors++; $display("FAIL rand_stall c%0d: got %b want %b", c, o_alu_stall, exp_stall); end
      tick();
      checks++; if (o_rd_wren !== m_wren || o_rd_addr !== m_addr || o_rd_data !== m_data) begin
        errors++;
        $display("FAIL rand_out c%0d: got %b/%0d/%h want %b/%0d/%h", c, o_rd_wren, o_rd_addr, o_rd_data,
                 m_wren, m_addr, m_data);
      end
    end
    i_reset = 1'b0;
    idle_inputs();
  endtask

  initial begin
    test_reset();
    test_alu_only();
    test_x0();
    test_extend();
    test_starvation();
    test_full_reset();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
